culsans_exit_ctrl: RTL and testbench
====================================

Name: culsans_exit_ctrl

Overview:
- Memory-mapped end-of-simulation controller inside culsans_top; its output is the exit_o[31:0] the SoC exports.
- Software writes a tohost word.
- The block latches the exit code and raises exit_o[0].
- A built-in watchdog forces a timeout exit code if software never finishes, so the bench cannot hang.

Parameters:
- AddrWidth, 12, width of the byte offset seen by the slave port.
- TimeoutCycles, 64'd10_000_000, clk_i cycles after reset before the watchdog fires; 0 disables the watchdog.
- TimeoutCode, 31'h7EAD, exit code reported on watchdog expiry.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- req_i  input  1  slave request valid
- we_i  input  1  1 = write, 0 = read
- addr_i  input  AddrWidth  byte offset; bits [2:0] ignored
- wdata_i  input  64  write data
- be_i  input  8  byte enables
- gnt_o  output  1  request accepted
- rvalid_o  output  1  response valid (reads and writes)
- rdata_o  output  64  read data
- exit_o  output  32  {code[30:0], done}

Behaviour:
- Single clock domain: clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, exit_o=0, all registers 0, FSM=RUN.
- Register map (64-bit words):
  - 0x00 TOHOST: RW.
  - 0x08 CTRL: RW. Bit0 = watchdog enable, reset value 1. Bit1 = W1 kick, clears the cycle counter; reads as 0.
  - 0x10 CYCLE: RO free-running cycle counter.
  - 0x18 STATUS: RO. Bit0 = done, bit1 = timeout, bits[32:2] = latched code.
- Unmapped offsets: reads return 0, writes are ignored.
- Handshake:
  - gnt_o is combinational and equals req_i; every request is accepted in the cycle presented.
  - rvalid_o is asserted exactly one cycle after each accepted request.
  - rdata_o is valid with rvalid_o and held otherwise.
  - Back-to-back requests every cycle are supported.
- Writes honour be_i per byte. be_i=0 is a no-op but still produces an rvalid_o response.
- FSM states: RUN, DONE_SW, DONE_TO.
  - RUN -> DONE_SW: on a write to TOHOST whose resulting value has bit0=1. code := resulting value[31:1]. exit_o updates the cycle after the write is accepted.
  - RUN -> DONE_TO: when the watchdog is enabled, TimeoutCycles != 0, and CYCLE reaches TimeoutCycles-1. code := TimeoutCode. exit_o is asserted the next cycle.
  - A TOHOST write with bit0=0 updates TOHOST only; it does not terminate.
  - Simultaneous TOHOST-terminate write and watchdog expiry in the same cycle: the software write wins, giving DONE_SW with STATUS.timeout=0.
  - DONE_SW and DONE_TO are sticky until reset. Further TOHOST writes still update TOHOST but never change exit_o or the code.
- exit_o = {code[30:0], 1'b1} in either DONE state, 0 in RUN.
- CYCLE:
  - 64-bit; increments every cycle in RUN and freezes in DONE states.
  - A kick resets it to 0 on the following cycle.
  - At 2^64-1 it saturates and does not wrap.
- Reset asserted mid-operation, including mid-response: all state clears immediately. A pending rvalid_o is dropped. exit_o returns to 0.

Test Plan:
1. Reset, then write TOHOST=64'h1, be=FF -> gnt_o same cycle, rvalid_o next cycle, exit_o=32'h1 one cycle after the grant. STATUS read returns 64'h1.
2. Write TOHOST=64'h2B (code 0x15) -> exit_o=32'h2B. A later write TOHOST=64'h5 leaves exit_o=32'h2B; a TOHOST read returns 64'h5.
3. Run with TimeoutCycles=100 and no writes -> exit_o=32'hFD5B ((0x7EAD<<1)|1) at cycle 100 after reset release. STATUS bit1=1. CYCLE frozen at 99.
4. TimeoutCycles=100; write CTRL bit1 kick at cycle 50 -> no expiry until cycle 151. Write CTRL=0 (watchdog disabled) -> no expiry for 1000 cycles.
5. Write TOHOST=64'h3 in the exact cycle the watchdog expires -> exit_o=32'h3 and STATUS timeout=0. Separately, a partial write be=8'h01 with wdata=64'hFF -> TOHOST=64'hFF, exit_o=32'hFF.
6. Issue back-to-back reads of 0x10 then 0x20 -> two consecutive rvalid_o; the second returns 0. Assert rst_ni low while rvalid_o is pending -> rvalid_o=0 and exit_o=0 immediately.

Source files
------------

// File: rtl/culsans_exit_ctrl.sv
// End-of-simulation controller: latches a software tohost exit code or a
// watchdog timeout code and presents it on exit_o as {code, done}.
module culsans_exit_ctrl #(
  parameter int unsigned AddrWidth     = 12,
  parameter logic [63:0] TimeoutCycles = 64'd10_000_000,
  parameter logic [30:0] TimeoutCode   = 31'h7EAD
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [63:0]          wdata_i,
  input  logic [7:0]           be_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [63:0]          rdata_o,
  output logic [31:0]          exit_o
);

  // state   | meaning
  // RUN     | simulation running, cycle counter and watchdog active
  // DONE_SW | software wrote a terminating tohost word (sticky)
  // DONE_TO | watchdog expired before software finished (sticky)
  typedef enum logic [1:0] {RUN, DONE_SW, DONE_TO} state_t;

  localparam int unsigned WW = AddrWidth - 3;

  state_t        state;
  logic [63:0]   tohost;
  logic [63:0]   cycle;
  logic          wd_en;
  logic [30:0]   code;

  logic [WW-1:0] word;
  logic [63:0]   bmask;
  logic [63:0]   tohost_next;
  logic [63:0]   rdata_mux;
  logic          wr, rd;
  logic          sel_tohost, sel_ctrl, sel_cycle, sel_status;
  logic          tohost_wr, ctrl_wr, kick, sw_term, wd_fire;

  assign gnt_o = req_i;
  assign word  = addr_i[AddrWidth-1:3];
  assign wr    = req_i & we_i;
  assign rd    = req_i & ~we_i;

  assign sel_tohost = (word == WW'(0));
  assign sel_ctrl   = (word == WW'(1));
  assign sel_cycle  = (word == WW'(2));
  assign sel_status = (word == WW'(3));

  always_comb begin
    bmask = '0;
    for (int i = 0; i < 8; i++) bmask[i*8 +: 8] = {8{be_i[i]}};
  end

  assign tohost_next = (tohost & ~bmask) | (wdata_i & bmask);
  assign tohost_wr   = wr & sel_tohost & (|be_i);
  assign ctrl_wr     = wr & sel_ctrl & be_i[0];
  assign kick        = ctrl_wr & wdata_i[1] & (state == RUN);
  assign sw_term     = tohost_wr & tohost_next[0] & (state == RUN);
  // Software termination is evaluated first, so it wins a same-cycle expiry.
  assign wd_fire     = (state == RUN) & wd_en & (TimeoutCycles != 64'd0) &
                       (cycle == TimeoutCycles - 64'd1);

  always_comb begin
    rdata_mux = '0;
    if (sel_tohost)      rdata_mux = tohost;
    else if (sel_ctrl)   rdata_mux = {63'd0, wd_en};
    else if (sel_cycle)  rdata_mux = cycle;
    else if (sel_status) rdata_mux = {31'd0, code, state == DONE_TO, state != RUN};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= RUN;
      tohost   <= '0;
      cycle    <= '0;
      wd_en    <= 1'b1;
      code     <= '0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      exit_o   <= '0;
    end else begin
      rvalid_o <= req_i;
      if (rd) rdata_o <= rdata_mux;
      if (tohost_wr) tohost <= tohost_next;
      if (ctrl_wr) wd_en <= wdata_i[0];

      // Counter freezes on the terminating edge too, so it reads TimeoutCycles-1.
      if (kick)
        cycle <= '0;
      else if (state == RUN && !sw_term && !wd_fire && cycle != '1)
        cycle <= cycle + 64'd1;

      case (state)
        RUN: begin
          if (sw_term) begin
            state  <= DONE_SW;
            code   <= tohost_next[31:1];
            exit_o <= {tohost_next[31:1], 1'b1};
          end else if (wd_fire) begin
            state  <= DONE_TO;
            code   <= TimeoutCode;
            exit_o <= {TimeoutCode, 1'b1};
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_culsans_exit_ctrl.sv
// Scoreboard bench for culsans_exit_ctrl with a 100-cycle watchdog.
module tb_culsans_exit_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [11:0] addr_i = '0;
  logic [63:0] wdata_i = '0;
  logic [7:0]  be_i = '0;
  logic        gnt_o;
  logic        rvalid_o;
  logic [63:0] rdata_o;
  logic [31:0] exit_o;

  culsans_exit_ctrl #(
    .AddrWidth(12),
    .TimeoutCycles(64'd100),
    .TimeoutCode(31'h7EAD)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .exit_o(exit_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          due;
    bit          chk;
    logic [63:0] data;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   ncyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge clk_i) ncyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // Monitor: each response must appear exactly one cycle after its request.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      while (sb.size() > 0 && sb[0].due < ncyc) begin
        exp_t e;
        e = sb.pop_front();
        n_total++;
        $display("FAIL %s: response missed its cycle", e.name);
      end
      if (sb.size() > 0 && sb[0].due == ncyc) begin
        exp_t e;
        e = sb.pop_front();
        n_total++;
        if (!rvalid_o)
          $display("FAIL %s: rvalid_o got 0 expected 1", e.name);
        else if (e.chk && rdata_o !== e.data)
          $display("FAIL %s: rdata got %h expected %h", e.name, rdata_o, e.data);
        else
          n_pass++;
      end else if (rvalid_o) begin
        n_total++;
        $display("FAIL spurious_rvalid: got 1 expected 0");
      end
    end
  end

  task automatic bus(input logic we, input logic [11:0] addr, input logic [63:0] wd,
                     input logic [7:0] be, input bit chk, input logic [63:0] exp,
                     input string nm);
    exp_t e;
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd; be_i = be;
    e.due = ncyc + 1; e.chk = chk; e.data = exp; e.name = nm;
    sb.push_back(e);
    #1 check({nm, "_gnt"}, {63'd0, gnt_o}, 64'd1);
    @(negedge clk_i);
  endtask

  task automatic idle();
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    // Reset values
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_gnt", {63'd0, gnt_o}, 64'd0);
    check("rst_rvalid", {63'd0, rvalid_o}, 64'd0);
    check("rst_rdata", rdata_o, 64'd0);
    check("rst_exit", {32'd0, exit_o}, 64'd0);
    rst_ni = 1'b1;

    // 1: terminating write of 1
    bus(1'b1, 12'h000, 64'h1, 8'hFF, 1'b0, 64'd0, "t1_wr");
    idle();
    check("t1_exit", {32'd0, exit_o}, 64'h1);
    bus(1'b0, 12'h018, 64'd0, 8'h00, 1'b1, 64'h1, "t1_status");
    idle();
    @(negedge clk_i);

    // 2: code sticks after later writes
    do_reset();
    bus(1'b1, 12'h000, 64'h2B, 8'hFF, 1'b0, 64'd0, "t2_wr");
    idle();
    check("t2_exit", {32'd0, exit_o}, 64'h2B);
    bus(1'b1, 12'h000, 64'h5, 8'hFF, 1'b0, 64'd0, "t2_wr2");
    idle();
    check("t2_exit_sticky", {32'd0, exit_o}, 64'h2B);
    bus(1'b0, 12'h000, 64'd0, 8'h00, 1'b1, 64'h5, "t2_tohost");
    bus(1'b0, 12'h018, 64'd0, 8'h00, 1'b1, 64'h55, "t2_status");
    idle();
    @(negedge clk_i);

    // 3: watchdog expiry at cycle 100
    do_reset();
    repeat (99) @(negedge clk_i);
    check("t3_exit_before", {32'd0, exit_o}, 64'd0);
    @(negedge clk_i);
    check("t3_exit_timeout", {32'd0, exit_o}, 64'hFD5B);
    bus(1'b0, 12'h018, 64'd0, 8'h00, 1'b1, 64'h1FAB7, "t3_status");
    bus(1'b0, 12'h010, 64'd0, 8'h00, 1'b1, 64'd99, "t3_cycle");
    idle();
    @(negedge clk_i);

    // 4: kick at cycle 50 delays expiry to cycle 151; disabled watchdog never fires
    do_reset();
    repeat (50) @(negedge clk_i);
    bus(1'b1, 12'h008, 64'h3, 8'h01, 1'b0, 64'd0, "t4_kick");
    idle();
    repeat (99) @(negedge clk_i);
    check("t4_exit_before", {32'd0, exit_o}, 64'd0);
    @(negedge clk_i);
    check("t4_exit_timeout", {32'd0, exit_o}, 64'hFD5B);
    do_reset();
    bus(1'b1, 12'h008, 64'h0, 8'hFF, 1'b0, 64'd0, "t4_disable");
    idle();
    repeat (1000) @(negedge clk_i);
    check("t4_exit_disabled", {32'd0, exit_o}, 64'd0);
    bus(1'b0, 12'h008, 64'd0, 8'h00, 1'b1, 64'd0, "t4_ctrl");
    idle();
    @(negedge clk_i);

    // 5: software write in the expiry cycle wins; partial byte write
    do_reset();
    repeat (99) @(negedge clk_i);
    bus(1'b1, 12'h000, 64'h3, 8'hFF, 1'b0, 64'd0, "t5_race_wr");
    idle();
    check("t5_exit_race", {32'd0, exit_o}, 64'h3);
    bus(1'b0, 12'h018, 64'd0, 8'h00, 1'b1, 64'h5, "t5_status");
    idle();
    @(negedge clk_i);
    do_reset();
    bus(1'b1, 12'h000, 64'hFF, 8'h01, 1'b0, 64'd0, "t5_part_wr");
    idle();
    check("t5_exit_part", {32'd0, exit_o}, 64'hFF);
    bus(1'b0, 12'h000, 64'd0, 8'h00, 1'b1, 64'hFF, "t5_tohost");
    idle();
    @(negedge clk_i);

    // 6: back-to-back reads, unmapped read, reset mid-response
    do_reset();
    repeat (5) @(negedge clk_i);
    bus(1'b0, 12'h010, 64'd0, 8'h00, 1'b1, 64'd5, "t6_cycle");
    bus(1'b0, 12'h020, 64'd0, 8'h00, 1'b1, 64'd0, "t6_unmapped");
    idle();
    bus(1'b1, 12'h000, 64'h7, 8'hFF, 1'b0, 64'd0, "t6_wr");
    idle();
    @(negedge clk_i);
    check("t6_exit", {32'd0, exit_o}, 64'h7);
    req_i = 1'b1; we_i = 1'b0; addr_i = 12'h000;
    @(posedge clk_i);
    #1;
    idle();
    check("t6_rvalid_pending", {63'd0, rvalid_o}, 64'd1);
    rst_ni = 1'b0;
    sb.delete();
    #1;
    check("t6_rst_rvalid", {63'd0, rvalid_o}, 64'd0);
    check("t6_rst_exit", {32'd0, exit_o}, 64'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
